// File: rtl/tri_feeder_pkg.sv
// ----------------------------------------------------------------------------
// tri_feeder_pkg
// Shared definitions for the triangle-vertex feeder:
//   - state encoding of the streaming FSM (IDLE .. WAIT_FIN)
//   - vertex slot offsets inside one triangle record (V0/V1/V2)
//   - vertex_slot(): which vertex of a triangle a streaming state presents
// ----------------------------------------------------------------------------
package tri_feeder_pkg;

    localparam logic [2:0] ENC_IDLE     = 3'd0;
    localparam logic [2:0] ENC_V1       = 3'd1;
    localparam logic [2:0] ENC_V2       = 3'd2;
    localparam logic [2:0] ENC_V3       = 3'd3;
    localparam logic [2:0] ENC_WAIT_ACK = 3'd4;
    localparam logic [2:0] ENC_WAIT_FIN = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ENC_IDLE,
        S_V1       = ENC_V1,
        S_V2       = ENC_V2,
        S_V3       = ENC_V3,
        S_WAIT_ACK = ENC_WAIT_ACK,
        S_WAIT_FIN = ENC_WAIT_FIN
    } state_t;

    localparam logic [1:0] VTX_V0 = 2'd0;
    localparam logic [1:0] VTX_V1 = 2'd1;
    localparam logic [1:0] VTX_V2 = 2'd2;

    // Vertex slot shown while sitting in a given state; non-vertex states map to V0
    function automatic logic [1:0] vertex_slot(input state_t s);
        logic [1:0] slot;
        case (s)
            S_V1:    slot = VTX_V0;
            S_V2:    slot = VTX_V1;
            S_V3:    slot = VTX_V2;
            default: slot = VTX_V0;
        endcase
        return slot;
    endfunction

endpackage

// File: rtl/tri_vertex_table.sv
// ----------------------------------------------------------------------------
// tri_vertex_table
// Vertex register file, DEPTH entries of {x, y}. Cleared by the asynchronous
// reset, written on the falling clock edge, read combinationally.
// Ports:
//   clk      in   clock (writes on falling edge)
//   reset    in   asynchronous active-high clear of every entry
//   wr_en    in   write strobe (already qualified by the caller)
//   wr_addr  in   write slot; slots >= DEPTH are ignored
//   wr_data  in   {x, y} to store
//   rd_addr  in   read slot; slots >= DEPTH read as zero
//   rd_data  out  {x, y} stored at rd_addr
// ----------------------------------------------------------------------------
module tri_vertex_table #(
    parameter int COORD_W = 3,
    parameter int DEPTH   = 12,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [2*COORD_W-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [2*COORD_W-1:0] rd_data
);

    logic [2*COORD_W-1:0] mem_r [DEPTH];

    // Storage: cleared on reset, single write port on the falling edge
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(2*COORD_W){1'b0}};
            end
        end else if (wr_en && (wr_addr < AW'(DEPTH))) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Combinational read with out-of-range slots returning zero
    always_comb begin
        rd_data = {(2*COORD_W){1'b0}};
        if (rd_addr < AW'(DEPTH)) begin
            rd_data = mem_r[rd_addr];
        end else begin
            rd_data = {(2*COORD_W){1'b0}};
        end
    end

endmodule

// File: rtl/tri_vertex_feeder.sv
// ----------------------------------------------------------------------------
// tri_vertex_feeder
// Programmable triangle-vertex source feeding the rasterizer. A table of up to
// MAX_TRI triangles is loaded while idle; a start request streams tri_cnt
// triangles, one vertex per cycle, waiting for the rasterizer to accept
// (busy rising) and finish (busy falling) each one. Optional looping.
// All state and outputs update on the falling clock edge.
// Ports:
//   clk, reset                 clock (falling edge), async active-high reset
//   wr_en/wr_addr/wr_x/wr_y    table write port, honoured only while idle
//   tri_cnt, start, loop_en    pass length, start pulse, restart-after-last
//   busy                       rasterizer busy
//   nt, xo, yo, tri_idx        new-triangle strobe, vertex, triangle index
//   active, done, err          non-idle flag, pass-complete and error pulses
// ----------------------------------------------------------------------------
module tri_vertex_feeder
    import tri_feeder_pkg::*;
#(
    parameter int COORD_W = 3,
    parameter int MAX_TRI = 4,
    parameter int ACK_TO  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(3*MAX_TRI)-1:0] wr_addr,
    input  logic [COORD_W-1:0]           wr_x,
    input  logic [COORD_W-1:0]           wr_y,
    input  logic [$clog2(MAX_TRI+1)-1:0] tri_cnt,
    input  logic                         start,
    input  logic                         loop_en,
    input  logic                         busy,
    output logic                         nt,
    output logic [COORD_W-1:0]           xo,
    output logic [COORD_W-1:0]           yo,
    output logic [$clog2(MAX_TRI)-1:0]   tri_idx,
    output logic                         active,
    output logic                         done,
    output logic                         err
);

    localparam int DEPTH = 3 * MAX_TRI;
    localparam int AW    = $clog2(DEPTH);
    localparam int TC_W  = $clog2(MAX_TRI + 1);
    localparam int TI_W  = $clog2(MAX_TRI);
    localparam int TO_W  = $clog2(ACK_TO + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TO - 1);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

    state_t                 state_r, state_nx_s;
    logic                   pending_r, pending_nx_s;
    logic [TC_W-1:0]        cnt_r, cnt_nx_s;
    logic [TI_W-1:0]        idx_nx_s;
    logic [TO_W-1:0]        to_cnt_r, to_nx_s;
    logic                   done_nx_s, err_nx_s;
    logic                   cnt_bad_s, last_tri_s, tbl_we_s, vtx_state_s;
    logic [AW-1:0]          rd_addr_s;
    logic [2*COORD_W-1:0]   rd_data_s;
    logic [COORD_W-1:0]     xo_nx_s, yo_nx_s;

    assign cnt_bad_s  = (tri_cnt == {TC_W{1'b0}}) || (tri_cnt > TC_W'(MAX_TRI));
    assign last_tri_s = !((TC_W'(tri_idx) + TC_W'(1'b1)) < cnt_r);
    // Table is writable only while nothing is being streamed
    assign tbl_we_s   = wr_en && (state_r == S_IDLE);
    // Read the vertex the next state will present, so xo/yo can be registered
    assign rd_addr_s  = AW'(idx_nx_s) * AW'(2'd3) + AW'(vertex_slot(state_nx_s));
    assign vtx_state_s = (state_nx_s == S_V1) || (state_nx_s == S_V2) || (state_nx_s == S_V3);

    tri_vertex_table #(
        .COORD_W (COORD_W),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tbl_we_s),
        .wr_addr (wr_addr),
        .wr_data ({wr_x, wr_y}),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Next-state, pass bookkeeping and pulse decisions
    always_comb begin
        state_nx_s   = state_r;
        pending_nx_s = pending_r;
        cnt_nx_s     = cnt_r;
        idx_nx_s     = tri_idx;
        to_nx_s      = to_cnt_r;
        done_nx_s    = 1'b0;
        err_nx_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (cnt_bad_s) begin
                        err_nx_s = 1'b1;
                    end else begin
                        pending_nx_s = 1'b1;
                        cnt_nx_s     = tri_cnt;
                    end
                end else if (pending_r && !busy) begin
                    // pending is consumed here so an aborted pass never restarts by itself
                    state_nx_s   = S_V1;
                    idx_nx_s     = {TI_W{1'b0}};
                    pending_nx_s = 1'b0;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_V1: state_nx_s = S_V2;
            S_V2: state_nx_s = S_V3;
            S_V3: begin
                state_nx_s = S_WAIT_ACK;
                to_nx_s    = {TO_W{1'b0}};
            end
            S_WAIT_ACK: begin
                if (busy) begin
                    state_nx_s = S_WAIT_FIN;
                end else if (to_cnt_r >= TO_LAST) begin
                    state_nx_s = S_IDLE;
                    err_nx_s   = 1'b1;
                end else if (to_cnt_r != TO_MAX) begin
                    to_nx_s = to_cnt_r + TO_W'(1'b1);
                end else begin
                    to_nx_s = to_cnt_r;
                end
            end
            S_WAIT_FIN: begin
                if (busy) begin
                    state_nx_s = S_WAIT_FIN;
                end else if (!last_tri_s) begin
                    state_nx_s = S_V1;
                    idx_nx_s   = tri_idx + TI_W'(1'b1);
                end else if (loop_en) begin
                    state_nx_s = S_V1;
                    idx_nx_s   = {TI_W{1'b0}};
                end else begin
                    state_nx_s   = S_IDLE;
                    done_nx_s    = 1'b1;
                    pending_nx_s = 1'b0;
                end
            end
            default: begin
                state_nx_s   = S_IDLE;
                pending_nx_s = 1'b0;
            end
        endcase
    end

    // Vertex outputs: table data in V1..V3, zero everywhere else
    always_comb begin
        xo_nx_s = {COORD_W{1'b0}};
        yo_nx_s = {COORD_W{1'b0}};
        if (vtx_state_s) begin
            xo_nx_s = rd_data_s[2*COORD_W-1:COORD_W];
            yo_nx_s = rd_data_s[COORD_W-1:0];
        end else begin
            xo_nx_s = {COORD_W{1'b0}};
            yo_nx_s = {COORD_W{1'b0}};
        end
    end

    // State, counters and registered outputs, all on the falling edge
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            pending_r <= 1'b0;
            cnt_r     <= {TC_W{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
            tri_idx   <= {TI_W{1'b0}};
            nt        <= 1'b0;
            xo        <= {COORD_W{1'b0}};
            yo        <= {COORD_W{1'b0}};
            active    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pending_r <= pending_nx_s;
            cnt_r     <= cnt_nx_s;
            to_cnt_r  <= to_nx_s;
            tri_idx   <= idx_nx_s;
            nt        <= (state_nx_s == S_V1);
            xo        <= xo_nx_s;
            yo        <= yo_nx_s;
            active    <= (state_nx_s != S_IDLE);
            done      <= done_nx_s;
            err       <= err_nx_s;
        end
    end

endmodule

// File: tb/tb_tri_vertex_feeder.sv
// ----------------------------------------------------------------------------
// tb_tri_vertex_feeder
// Self-checking bench for tri_vertex_feeder. Inputs are driven and outputs
// sampled on the rising edge (the DUT acts on the falling edge). A table
// model plus a "next expected triangle" index predicts every streamed
// triangle; a small busy responder plays the rasterizer.
// ----------------------------------------------------------------------------
module tb_tri_vertex_feeder;

    localparam int NSLOT = 12;

    logic       clk = 1'b0;
    logic       reset, wr_en, start, loop_en, busy;
    logic [3:0] wr_addr;
    logic [2:0] wr_x, wr_y, tri_cnt;
    logic       nt, active, done, err;
    logic [2:0] xo, yo;
    logic [1:0] tri_idx;

    int checks = 0;
    int failures = 0;

    logic [5:0] tbl_m [NSLOT];
    logic [5:0] cap [3];
    int cap_i, exp_idx, m_cnt;
    int n_nt, n_done, n_err, cyc, nt_cyc, err_cyc;
    bit bm_en;
    int bm_d, bm_h, bm_rise, bm_hold;

    tri_vertex_feeder #(.COORD_W(3), .MAX_TRI(4), .ACK_TO(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_y(wr_y), .tri_cnt(tri_cnt), .start(start),
        .loop_en(loop_en), .busy(busy), .nt(nt), .xo(xo), .yo(yo),
        .tri_idx(tri_idx), .active(active), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One DUT falling edge, then sample at the rising edge and react.
    task automatic step();
        logic busy_seen;
        busy_seen = busy;
        @(posedge clk);
        cyc++;
        if (done === 1'b1) n_done++;
        if (err === 1'b1) begin
            n_err++;
            err_cyc = cyc;
        end
        if (nt === 1'b1) begin
            check("nt_while_busy", 32'(busy_seen), 32'd0);
            check("tri_idx", 32'(tri_idx), 32'(exp_idx));
            n_nt++;
            nt_cyc = cyc;
            cap[0] = {xo, yo};
            cap_i = 1;
            if (bm_en) bm_rise = bm_d;
        end else if (cap_i > 0) begin
            cap[cap_i] = {xo, yo};
            cap_i++;
            if (cap_i == 3) begin
                for (int v = 0; v < 3; v++)
                    check("vertex", 32'(cap[v]), 32'(tbl_m[3*exp_idx+v]));
                exp_idx = (exp_idx + 1 < m_cnt) ? exp_idx + 1 : 0;
                cap_i = 0;
            end
        end
        // rasterizer model: rise bm_d cycles after nt, hold bm_h cycles
        if (bm_rise > 0) begin
            bm_rise--;
            if (bm_rise == 0) begin
                busy = 1'b1;
                bm_hold = bm_h;
            end
        end else if (bm_hold > 0) begin
            bm_hold--;
            if (bm_hold == 0) busy = 1'b0;
        end
    endtask

    task automatic wr(input int addr, input int x, input int y, input bit taken);
        wr_en = 1'b1;
        wr_addr = addr[3:0];
        wr_x = x[2:0];
        wr_y = y[2:0];
        step();
        wr_en = 1'b0;
        if (taken && addr < NSLOT) tbl_m[addr] = {x[2:0], y[2:0]};
    endtask

    task automatic start_pass(input int cnt);
        tri_cnt = cnt[2:0];
        m_cnt = cnt;
        exp_idx = 0;
        n_nt = 0;
        n_done = 0;
        n_err = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget && n_done == 0 && n_err == 0) begin
            step();
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic expect_pass(input string tag, input int cnt);
        check({tag, "_nt"}, 32'(n_nt), 32'(cnt));
        check({tag, "_done"}, 32'(n_done), 32'd1);
        check({tag, "_err"}, 32'(n_err), 32'd0);
        check({tag, "_active"}, 32'(active), 32'd0);
    endtask

    initial begin
        int c;
        reset = 1'b1; wr_en = 1'b0; start = 1'b0; loop_en = 1'b0; busy = 1'b0;
        wr_addr = 4'd0; wr_x = 3'd0; wr_y = 3'd0; tri_cnt = 3'd0;
        cap_i = 0; exp_idx = 0; m_cnt = 1; cyc = 0; nt_cyc = 0; err_cyc = 0;
        n_nt = 0; n_done = 0; n_err = 0;
        bm_en = 1'b1; bm_d = 2; bm_h = 5; bm_rise = 0; bm_hold = 0;
        for (int i = 0; i < NSLOT; i++) tbl_m[i] = 6'd0;

        // 1: reset values, then a read-back of the cleared table
        #12;
        check("rst_nt", 32'(nt), 32'd0);
        check("rst_xo", 32'(xo), 32'd0);
        check("rst_yo", 32'(yo), 32'd0);
        check("rst_tri_idx", 32'(tri_idx), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        reset = 1'b0;
        start_pass(1);
        run_until_idle("t1_bound", 60);
        expect_pass("t1", 1);

        // 2: two directed triangles, busy 2 cycles after nt for 5 cycles
        wr(0, 1, 1, 1); wr(1, 4, 1, 1); wr(2, 1, 7, 1);
        wr(3, 1, 1, 1); wr(4, 7, 1, 1); wr(5, 1, 3, 1);
        wr(13, 5, 5, 0);
        bm_d = 2; bm_h = 5;
        start_pass(2);
        run_until_idle("t2_bound", 80);
        expect_pass("t2", 2);

        // 3: start while busy is held; nt only after busy drops
        bm_en = 1'b0;
        busy = 1'b1;
        start_pass(1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_nt_held", 32'(nt), 32'd0);
        end
        bm_en = 1'b1;
        busy = 1'b0;
        step();
        check("t3_nt_after_release", 32'(nt), 32'd1);
        run_until_idle("t3_bound", 60);
        expect_pass("t3", 1);

        // 4: no acknowledge -> err 16 cycles after WAIT_ACK entry, no done
        bm_en = 1'b0;
        start_pass(1);
        run_until_idle("t4_bound", 60);
        check("t4_err_cnt", 32'(n_err), 32'd1);
        check("t4_err_delay", 32'(err_cyc - nt_cyc), 32'd19);
        check("t4_active", 32'(active), 32'd0);
        for (int k = 0; k < 3; k++) step();
        check("t4_no_done", 32'(n_done), 32'd0);
        check("t4_nt_cnt", 32'(n_nt), 32'd1);

        // 5: looping, then dropping loop_en ends after the current pass
        bm_en = 1'b1; bm_d = 2; bm_h = 4;
        loop_en = 1'b1;
        start_pass(1);
        for (int k = 0; k < 200 && n_nt < 3; k++) step();
        check("t5_looped", 32'(n_nt), 32'd3);
        loop_en = 1'b0;
        run_until_idle("t5_bound", 60);
        expect_pass("t5", 3);
        // bad counts
        start_pass(0);
        check("t5_err_cnt0", 32'(err), 32'd1);
        step();
        check("t5_err_pulse", 32'(err), 32'd0);
        start_pass(5);
        check("t5_err_cnt5", 32'(err), 32'd1);
        step();
        check("t5_bad_no_nt", 32'(n_nt), 32'd0);
        check("t5_bad_active", 32'(active), 32'd0);

        // randomized table contents, pass lengths and busy timing
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < NSLOT; s++)
                wr(s, $urandom_range(0, 7), $urandom_range(0, 7), 1);
            wr($urandom_range(12, 15), $urandom_range(0, 7), $urandom_range(0, 7), 0);
            c = $urandom_range(1, 4);
            bm_d = $urandom_range(1, 5);
            bm_h = $urandom_range(4, 7);
            start_pass(c);
            run_until_idle("rnd_bound", 200);
            expect_pass("rnd", c);
        end

        // 6: write during V2 is ignored
        bm_d = 2; bm_h = 4;
        start_pass(1);
        for (int k = 0; k < 20 && n_nt == 0; k++) step();
        check("t6_nt_seen", 32'(n_nt), 32'd1);
        step();
        wr_en = 1'b1; wr_addr = 4'd0; wr_x = ~tbl_m[0][5:3]; wr_y = ~tbl_m[0][2:0];
        step();
        wr_en = 1'b0;
        run_until_idle("t6a_bound", 60);
        expect_pass("t6a", 1);
        start_pass(1);
        run_until_idle("t6b_bound", 60);
        expect_pass("t6b", 1);
        // reset in V2: outputs clear at once, table reads zero afterwards
        start_pass(2);
        for (int k = 0; k < 20 && n_nt == 0; k++) step();
        step();
        check("t6_in_v2", 32'(active), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_nt", 32'(nt), 32'd0);
        check("t6_rst_xo", 32'(xo), 32'd0);
        check("t6_rst_yo", 32'(yo), 32'd0);
        check("t6_rst_idx", 32'(tri_idx), 32'd0);
        check("t6_rst_active", 32'(active), 32'd0);
        #1;
        reset = 1'b0;
        busy = 1'b0; bm_rise = 0; bm_hold = 0; cap_i = 0;
        for (int i = 0; i < NSLOT; i++) tbl_m[i] = 6'd0;
        start_pass(4);
        run_until_idle("t6c_bound", 200);
        expect_pass("t6c", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
